writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, number of load-result buffer entries (power of two, >= 2).
REQ-002 Parameter: STARVE_LIMIT, 8, cycles the buffer head may wait before the ALU port is blocked.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: alu_valid  input  1  ALU result offered.
REQ-006 Port: alu_addr  input  5  ALU destination register.
REQ-007 Port: alu_data  input  32  ALU result value.
REQ-008 Port: alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-009 Port: mem_valid  input  1  load result offered.
REQ-010 Port: mem_addr  input  5  load destination register.
REQ-011 Port: mem_data  input  32  load result value.
REQ-012 Port: mem_ready  output  1  load result accepted this cycle when mem_valid is also high.
REQ-013 Port: reg_write  output  1  register-file write enable, registered.
REQ-014 Port: write_addr  output  5  register-file write address, registered.
REQ-015 Port: write_data  output  32  register-file write data, registered.
REQ-016 Port: pend_mask  output  32  bit n set while any buffered load targets register n; bit 0 always 0.

Function
REQ-017 The block SHALL buffer accepted load results in a DEPTH-entry FIFO and SHALL issue at most one register write per cycle.
REQ-018 mem_ready SHALL equal "FIFO not full", independent of any same-cycle pop.
REQ-019 alu_ready SHALL be 0 when any valid FIFO entry holds a nonzero address equal to alu_addr (WAW ordering), or when the starvation counter equals STARVE_LIMIT; otherwise 1.
REQ-020 Select per cycle: an accepted ALU result wins; else the FIFO head is popped if the FIFO is non-empty; else nothing is issued.
REQ-021 The selected result SHALL appear on write_addr/write_data with reg_write=1 exactly one cycle after selection.
REQ-022 A selected result with address 0 SHALL be consumed (handshake completes, FIFO pops), but the next-cycle reg_write SHALL be 0.
REQ-023 When nothing is issued, reg_write SHALL be 0 and write_addr/write_data SHALL hold their previous values.
REQ-024 Starvation counter: cleared on a FIFO pop or when the FIFO is empty; otherwise incremented each cycle; saturates at STARVE_LIMIT.
REQ-025 Simultaneous push and pop on a non-empty FIFO SHALL keep the occupancy unchanged; a push into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-026 A push while full SHALL be impossible (mem_ready=0); an ignored mem_valid SHALL leave the FIFO unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy SHALL range from 0 to DEPTH inclusive.
REQ-028 pend_mask SHALL be derived combinationally from valid FIFO entries and SHALL update in the cycle after a push or pop takes effect.

Reset
REQ-029 While reset=1, independent of clk: FIFO empty, starvation counter 0, reg_write=0, write_addr=0, write_data=0, pend_mask=0, mem_ready=1, alu_ready=1.
REQ-030 Reset asserted with entries buffered SHALL discard them with no register write issued.
REQ-031 The first selection SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-032 ALU only: alu_valid=1, addr=5, data=0x1234 at cycle 0 -> cycle 1: reg_write=1, write_addr=5, write_data=0x00001234.
REQ-033 Ordering: load to r7=0xAA buffered, then ALU to r7=0xBB -> alu_ready=0 until the load is popped; writes occur in order 0xAA then 0xBB.
REQ-034 Full buffer: 5 back-to-back loads with ALU busy every cycle -> mem_ready=0 after the 4th accept; no data lost; pend_mask reflects all 4 addresses.
REQ-035 Starvation: ALU valid every cycle to r3 with one load buffered to r9 -> after 8 waiting cycles alu_ready=0 for one cycle; r9 written next cycle.
REQ-036 Address 0: load to r0 and ALU to r0 -> both handshakes complete; reg_write stays 0.
REQ-037 Reset mid-operation: 3 loads buffered, reset pulsed -> pend_mask=0 and reg_write=0 immediately, mem_ready=1; no stale write issued after release.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter_if
// Brief   : ALU/load result handshakes and register-file write port bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pend_mask;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, reg_write, write_addr, write_data, pend_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, reg_write, write_addr, write_data, pend_mask
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter
// Brief   : Single-port register writeback arbiter; ALU results bypass a
//           load-result FIFO, with WAW ordering and head-starvation relief.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    writeback_arbiter_if.slave wb
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE = c_STV_W'(STARVE_LIMIT);

    logic [4:0]          addr_q [DEPTH];
    logic [31:0]         data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [c_PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic [c_STV_W-1:0]  starve_q, starve_d;
    logic                reg_write_q, reg_write_d;
    logic [4:0]          waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic        w_full, w_empty, w_waw, w_starved, w_alu_rdy;
    logic        w_alu_fire, w_push, w_pop;
    logic [31:0] w_pend;

    // Scan buffered loads for pending destinations and WAW hazards.
    always_comb begin
        w_waw  = 1'b0;
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] != 5'd0)) begin
                w_pend[addr_q[i]] = 1'b1;
                if (addr_q[i] == wb.alu_addr) begin
                    w_waw = 1'b1;
                end
            end
        end
    end

    assign w_full     = (count_q == c_DEPTH);
    assign w_empty    = (count_q == '0);
    assign w_starved  = (starve_q == c_STARVE);
    assign w_alu_rdy  = !w_waw && !w_starved;
    assign w_alu_fire = wb.alu_valid && w_alu_rdy;
    assign w_push     = wb.mem_valid && !w_full;
    // Empty test uses current occupancy so a fresh push is never popped same cycle.
    assign w_pop      = !w_alu_fire && !w_empty;

    always_comb begin
        valid_d     = valid_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        starve_d    = starve_q;
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        count_d     = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        if (w_pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + c_PTR_W'(1);
        end
        if (w_push) begin
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + c_PTR_W'(1);
        end

        if (w_pop || w_empty) begin
            starve_d = '0;
        end else if (!w_starved) begin
            starve_d = starve_q + c_STV_W'(1);
        end

        if (w_alu_fire) begin
            reg_write_d = (wb.alu_addr != 5'd0);
            waddr_d     = wb.alu_addr;
            wdata_d     = wb.alu_data;
        end else if (w_pop) begin
            reg_write_d = (addr_q[rptr_q] != 5'd0);
            waddr_d     = addr_q[rptr_q];
            wdata_d     = data_q[rptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Payload storage needs no reset; entries are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[wptr_q] <= wb.mem_addr;
            data_q[wptr_q] <= wb.mem_data;
        end
    end

    assign wb.alu_ready  = w_alu_rdy;
    assign wb.mem_ready  = !w_full;
    assign wb.reg_write  = reg_write_q;
    assign wb.write_addr = waddr_q;
    assign wb.write_data = wdata_q;
    assign wb.pend_mask  = w_pend;

endmodule
`default_nettype wire
